avalon_packet_arbiter: RTL and testbench

//   Shares one Avalon-ST output stream among NUM_SRC packet sources using round-robin at packet granularity.

---
 rtl/avalon_st_if.sv | 23 ++
 rtl/avalon_packet_arbiter.sv | 133 +++++++++++++
 tb/tb_avalon_packet_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: payload plus valid/ready handshake.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
) ();
    localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;
    logic                             ready;

    modport master (
        output data, valid, sop, eop, empty,
        input  ready
    );

    modport slave (
        input  data, valid, sop, eop, empty,
        output ready
    );
endinterface

// File: rtl/avalon_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC Avalon-ST sources.
// Orphan non-sop words seen while idle are swallowed and flagged.
module avalon_packet_arbiter #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int NUM_SRC             = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_SRC*8*DATA_WIDTH_IN_BYTES-1:0]      in_data,
    input  logic [NUM_SRC-1:0]                            in_valid,
    input  logic [NUM_SRC-1:0]                            in_sop,
    input  logic [NUM_SRC-1:0]                            in_eop,
    input  logic [NUM_SRC*$clog2(DATA_WIDTH_IN_BYTES)-1:0] in_empty,
    output logic [NUM_SRC-1:0]                            in_ready,
    avalon_st_if.master                                   out_msg,
    output logic [$clog2(NUM_SRC)-1:0]                    grant_idx,
    output logic                                          busy,
    output logic                                          drop_error
);
    localparam int DW      = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);
    localparam int IDX_W   = $clog2(NUM_SRC);

    typedef enum logic {
        IDLE,
        FORWARD
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   start_q, start_d;
    logic               drop_q, drop_d;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] orphan;
    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;

    logic [DW-1:0]      sel_data;
    logic [EMPTY_W-1:0] sel_empty;
    logic               sel_valid;
    logic               sel_sop;
    logic               sel_eop;

    assign req    = in_valid & in_sop;
    assign orphan = in_valid & ~in_sop;

    // First requester at or after start_q, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = IDX_W'((int'(start_q) + k) % NUM_SRC);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign sel_data  = in_data[grant_q*DW +: DW];
    assign sel_empty = in_empty[grant_q*EMPTY_W +: EMPTY_W];
    assign sel_valid = in_valid[grant_q];
    assign sel_sop   = in_sop[grant_q];
    assign sel_eop   = in_eop[grant_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        start_d       = start_q;
        drop_d        = 1'b0;
        in_ready      = '0;
        busy          = 1'b0;
        out_msg.data  = '0;
        out_msg.empty = '0;
        out_msg.valid = 1'b0;
        out_msg.sop   = 1'b0;
        out_msg.eop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = orphan;
                drop_d   = |orphan;
                if (found) begin
                    grant_d = winner;
                    state_d = FORWARD;
                end
            end
            FORWARD: begin
                busy              = 1'b1;
                out_msg.data      = sel_data;
                out_msg.empty     = sel_empty;
                out_msg.valid     = sel_valid;
                out_msg.sop       = sel_sop;
                out_msg.eop       = sel_eop;
                in_ready[grant_q] = out_msg.ready;
                if (sel_valid && out_msg.ready && sel_eop) begin
                    state_d = IDLE;
                    start_d = (grant_q == IDX_W'(NUM_SRC - 1)) ?
                              '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Nothing handshakes while reset is held.
        if (rst) begin
            in_ready      = '0;
            out_msg.data  = '0;
            out_msg.empty = '0;
            out_msg.valid = 1'b0;
            out_msg.sop   = 1'b0;
            out_msg.eop   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            start_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            start_q <= start_d;
            drop_q  <= drop_d;
        end
    end

    assign grant_idx  = grant_q;
    assign drop_error = drop_q;
endmodule

// File: tb/tb_avalon_packet_arbiter.sv
// Randomized and directed bench for avalon_packet_arbiter.
module tb_avalon_packet_arbiter;
    localparam int DWB = 16;
    localparam int N   = 4;
    localparam int DW  = 8 * DWB;
    localparam int EW  = 4;
    localparam int IW  = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_valid, in_sop, in_eop, in_ready;
    logic [N*EW-1:0] in_empty;
    logic [IW-1:0] grant_idx;
    logic          busy, drop_error;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) bus ();

    avalon_packet_arbiter #(
        .DATA_WIDTH_IN_BYTES(DWB),
        .NUM_SRC(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_sop(in_sop),
        .in_eop(in_eop),
        .in_empty(in_empty),
        .in_ready(in_ready),
        .out_msg(bus),
        .grant_idx(grant_idx),
        .busy(busy),
        .drop_error(drop_error)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] s_data[N];
    logic [EW-1:0] s_empty[N];
    logic [N-1:0]  s_valid = '0;
    logic [N-1:0]  s_sop = '0;
    logic [N-1:0]  s_eop = '0;

    always_comb begin
        in_data  = '0;
        in_empty = '0;
        for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW]  = s_data[i];
            in_empty[i*EW +: EW] = s_empty[i];
        end
    end
    assign in_valid = s_valid;
    assign in_sop   = s_sop;
    assign in_eop   = s_eop;

    beat_t         src_q[N][$];
    logic [DW-1:0] fwd_q[N][$];
    int            pkt_seq[N];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    bit            chk_en = 1'b0;
    logic [N-1:0]  acc_lat = '0;
    int            gap_pct = 0;
    int            rdy_mode = 0;
    int            sop_log[$];
    int            xfer_cyc[$];
    int            xfer_src[N];

    // Reference: who owns the output and where the next search begins.
    bit            m_open = 1'b0;
    logic [IW-1:0] m_grant = '0;
    int            m_start = 0;
    bit            m_drop = 1'b0;
    bit            sb_open = 1'b0;
    int            sb_src = 0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            m_open  <= 1'b0;
            m_start <= 0;
            m_grant <= '0;
            m_drop  <= 1'b0;
        end else if (!m_open) begin
            int w;
            w = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_start + k) % N;
                if (w < 0 && s_valid[c] && s_sop[c]) w = c;
            end
            m_drop <= |(s_valid & ~s_sop);
            if (w >= 0) begin
                m_open  <= 1'b1;
                m_grant <= IW'(w);
            end
        end else begin
            m_drop <= 1'b0;
            if (s_valid[m_grant] && bus.ready && s_eop[m_grant]) begin
                m_open  <= 1'b0;
                m_start <= (int'(m_grant) + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0]  e_rdy;
        logic [DW-1:0] e_data;
        logic [EW-1:0] e_emp;
        logic          e_v, e_s, e_e;
        int            t;
        e_rdy  = '0;
        e_data = '0;
        e_emp  = '0;
        e_v    = 1'b0;
        e_s    = 1'b0;
        e_e    = 1'b0;
        if (!rst) begin
            if (m_open) begin
                e_v            = s_valid[m_grant];
                e_s            = s_sop[m_grant];
                e_e            = s_eop[m_grant];
                e_data         = s_data[m_grant];
                e_emp          = s_empty[m_grant];
                e_rdy[m_grant] = bus.ready;
            end else begin
                e_rdy = s_valid & ~s_sop;
            end
        end
        acc_lat <= s_valid & in_ready;
        if (chk_en) begin
            chk("out_valid", DW'(bus.valid), DW'(e_v));
            chk("out_sop", DW'(bus.sop), DW'(e_s));
            chk("out_eop", DW'(bus.eop), DW'(e_e));
            chk("out_data", bus.data, e_data);
            chk("out_empty", DW'(bus.empty), DW'(e_emp));
            chk("in_ready", DW'(in_ready), DW'(e_rdy));
            chk("busy", DW'(busy), DW'(m_open));
            chk("grant_idx", DW'(grant_idx), DW'(m_grant));
            chk("drop_error", DW'(drop_error), DW'(m_drop));
        end
        if (rst) begin
            sb_open <= 1'b0;
        end else if (bus.valid && bus.ready) begin
            t = int'(bus.data[DW-1 -: 8]);
            xfer_cyc.push_back(cyc);
            if (t < N) xfer_src[t]++;
            if (bus.sop) sop_log.push_back(t);
            if (t < N && fwd_q[t].size() > 0) begin
                chk("sb_data", bus.data, fwd_q[t].pop_front());
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_data: unexpected beat %0h", bus.data);
            end
            if (sb_open) chk("no_interleave", DW'(t), DW'(sb_src));
            if (bus.eop) begin
                sb_open <= 1'b0;
            end else if (bus.sop) begin
                sb_open <= 1'b1;
                sb_src  <= t;
            end
        end
    end

    task automatic push_pkt(input int s, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = {8'(s), 16'(pkt_seq[s]), 8'(i),
                       $urandom, $urandom, $urandom};
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = b.eop ? EW'($urandom) : '0;
            src_q[s].push_back(b);
            fwd_q[s].push_back(b.data);
        end
        pkt_seq[s]++;
    endtask

    task automatic push_orphan(input int s);
        beat_t b;
        b.data  = {8'(s), 16'hFFFF, 8'h00, $urandom, $urandom, $urandom};
        b.sop   = 1'b0;
        b.eop   = 1'b0;
        b.empty = '0;
        src_q[s].push_back(b);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            fwd_q[i].delete();
        end
        s_valid = '0;
        s_sop   = '0;
        s_eop   = '0;
    endtask

    function automatic int pending();
        int n;
        n = 0;
        for (int i = 0; i < N; i++) n += src_q[i].size();
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc_lat[i] && src_q[i].size() > 0)
                void'(src_q[i].pop_front());
        for (int i = 0; i < N; i++) begin
            if (s_valid[i] && !acc_lat[i]) begin
                // Avalon source keeps presenting until accepted.
            end else if (src_q[i].size() > 0 &&
                         $urandom_range(99) >= gap_pct) begin
                s_valid[i] = 1'b1;
                s_sop[i]   = src_q[i][0].sop;
                s_eop[i]   = src_q[i][0].eop;
                s_data[i]  = src_q[i][0].data;
                s_empty[i] = src_q[i][0].empty;
            end else begin
                s_valid[i] = 1'b0;
                s_sop[i]   = 1'b0;
                s_eop[i]   = 1'b0;
                s_data[i]  = {$urandom, $urandom, $urandom, $urandom};
                s_empty[i] = EW'($urandom);
            end
        end
        case (rdy_mode)
            1:       bus.ready = ~bus.ready;
            2:       bus.ready = ($urandom_range(99) < 70);
            default: bus.ready = 1'b1;
        endcase
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_seq();
        step();
        rst = 1'b1;
        clear_all();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((pending() > 0 || s_valid != '0 || m_open) && n < limit) begin
            step();
            n++;
        end
        chk("drain_done", DW'(pending()), '0);
        step();
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] pat;
        int         bcnt;
        int         n;
        int         exp2[5];
        for (int i = 0; i < N; i++) begin
            s_data[i]   = '0;
            s_empty[i]  = '0;
            pkt_seq[i]  = 0;
            xfer_src[i] = 0;
        end
        bus.ready = 1'b1;
        rst       = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;
        sample();
        chk("reset_grant", DW'(grant_idx), '0);
        chk("reset_ready", DW'(in_ready), '0);
        chk("reset_valid", DW'(bus.valid), '0);
        rst = 1'b0;

        // Three-beat packet from source 0 with one arbitration cycle.
        reset_seq();
        push_pkt(0, 3);
        pat  = '0;
        bcnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            sample();
            pat[c] = bus.valid & bus.ready;
            bcnt  += int'(busy);
            chk("t1_ready_others", DW'(in_ready[3:1]), '0);
        end
        chk("t1_pattern", DW'(pat), DW'(6'b001110));
        chk("t1_busy_cycles", DW'(bcnt), DW'(3));
        chk("t1_grant", DW'(grant_idx), '0);

        // Orphan word while idle.
        push_orphan(1);
        step();
        sample();
        chk("t4_ready1", DW'(in_ready[1]), DW'(1));
        chk("t4_out_valid", DW'(bus.valid), '0);
        chk("t4_drop_before", DW'(drop_error), '0);
        step();
        sample();
        chk("t4_drop_pulse", DW'(drop_error), DW'(1));
        step();
        sample();
        chk("t4_drop_after", DW'(drop_error), '0);

        // All four sources contend continuously.
        reset_seq();
        for (int s = 0; s < N; s++) begin
            push_pkt(s, 2);
            push_pkt(s, 2);
        end
        sop_log.delete();
        drain(200);
        exp2 = '{0, 1, 2, 3, 0};
        chk("t2_count", DW'(sop_log.size()), DW'(8));
        for (int i = 0; i < 5 && i < sop_log.size(); i++)
            chk("t2_order", DW'(sop_log[i]), DW'(exp2[i]));

        // Toggling backpressure.
        rdy_mode    = 1;
        xfer_src[2] = 0;
        push_pkt(2, 4);
        drain(100);
        chk("t3_beats", DW'(xfer_src[2]), DW'(4));
        rdy_mode = 0;

        // Reset in the middle of a five-beat packet.
        reset_seq();
        push_pkt(0, 5);
        xfer_src[0] = 0;
        n = 0;
        while (xfer_src[0] < 1 && n < 20) begin
            step();
            sample();
            n++;
        end
        chk("t5_first_beat", DW'(xfer_src[0]), DW'(1));
        step();
        rst = 1'b1;
        clear_all();
        step();
        sample();
        chk("t5_valid", DW'(bus.valid), '0);
        chk("t5_ready", DW'(in_ready), '0);
        chk("t5_busy", DW'(busy), '0);
        rst = 1'b0;
        push_pkt(0, 1);
        push_pkt(3, 1);
        sop_log.delete();
        drain(50);
        chk("t5_count", DW'(sop_log.size()), DW'(2));
        if (sop_log.size() > 0) chk("t5_winner", DW'(sop_log[0]), '0);

        // Back-to-back single-beat packets.
        xfer_cyc.delete();
        repeat (3) push_pkt(1, 1);
        drain(50);
        chk("t6_count", DW'(xfer_cyc.size()), DW'(3));
        for (int i = 1; i < xfer_cyc.size(); i++)
            chk("t6_spacing", DW'(xfer_cyc[i] - xfer_cyc[i-1]), DW'(2));
        chk("t6_grant", DW'(grant_idx), DW'(1));

        // Random traffic with gaps, orphans and random backpressure.
        gap_pct  = 25;
        rdy_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < N; s++) begin
                if (src_q[s].size() < 4 && $urandom_range(9) == 0) begin
                    if ($urandom_range(9) == 0) push_orphan(s);
                    push_pkt(s, $urandom_range(5, 1));
                end
            end
            step();
        end
        gap_pct  = 0;
        rdy_mode = 0;
        drain(3000);
        n = 0;
        for (int s = 0; s < N; s++) n += fwd_q[s].size();
        chk("fwd_left", DW'(n), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
